// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader.
// Includes the skid-buffer occupancy helper used by the read-issue logic.
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

    // Room exists if buffered + in-flight words, less this cycle's pop, fit.
    function automatic logic has_room(
        input logic [CNT_W-1:0] cnt,
        input logic             inflight,
        input logic             pop
    );
        logic [CNT_W:0] occ;
        occ = {1'b0, cnt}
            + {{CNT_W{1'b0}}, inflight}
            - {{CNT_W{1'b0}}, pop};
        return occ < (CNT_W + 1)'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry in-order buffer: write port in, valid/ready stream out.
// The head register holds its last value when the buffer drains.
module stream_skid2
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [CNT_W-1:0]      cnt_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pop;

    assign rd_valid_o = (cnt_q != '0);
    assign rd_data_o  = head_q;
    assign cnt_o      = cnt_q;
    assign pop        = rd_valid_o & rd_ready_i;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case ({wr_en_i, pop})
            2'b10: begin
                if (cnt_q == '0) begin
                    head_d = wr_data_i;
                end else begin
                    tail_d = wr_data_i;
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            2'b01: begin
                if (cnt_q == CNT_W'(SKID_DEPTH)) begin
                    head_d = tail_q;
                end
                cnt_d = cnt_q - CNT_W'(1);
            end
            2'b11: begin
                // Occupancy unchanged; the new word lands behind whatever remains.
                if (cnt_q == CNT_W'(SKID_DEPTH)) begin
                    head_d = tail_q;
                    tail_d = wr_data_i;
                end else begin
                    head_d = wr_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls a fixed-length burst from a one-cycle-latency FIFO onto a
// valid/ready stream, hiding the read latency behind a 2-entry skid buffer.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rden,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] issue_rem_q, issue_rem_d;
    logic [LEN_WIDTH-1:0] deliv_rem_q, deliv_rem_d;
    logic                 inflight_q;
    logic [CNT_W-1:0]     skid_cnt;
    logic                 pop;

    stream_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (inflight_q),
        .wr_data_i  (fifo_data),
        .rd_valid_o (m_valid),
        .rd_ready_i (m_ready),
        .rd_data_o  (m_data),
        .cnt_o      (skid_cnt)
    );

    assign pop  = m_valid & m_ready;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    assign m_last = m_valid & (deliv_rem_q == LEN_WIDTH'(1));

    // A pop this cycle frees a slot in time for the word this read returns.
    assign fifo_rden = (state_q == RUN)
                     & ~fifo_empty
                     & (issue_rem_q != '0)
                     & has_room(skid_cnt, inflight_q, pop);

    always_comb begin
        state_d     = state_q;
        issue_rem_d = issue_rem_q;
        deliv_rem_d = deliv_rem_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        issue_rem_d = len;
                        deliv_rem_d = len;
                        state_d     = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (fifo_rden) begin
                    issue_rem_d = issue_rem_q - LEN_WIDTH'(1);
                end
                if (pop) begin
                    deliv_rem_d = deliv_rem_q - LEN_WIDTH'(1);
                    if (deliv_rem_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_rem_q <= '0;
            deliv_rem_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_rem_q <= issue_rem_d;
            deliv_rem_q <= deliv_rem_d;
            inflight_q  <= fifo_rden;
        end
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side companion to the team's FIFO wrapper (registered-output FIFO with `rden`/`empty`/one-cycle read latency). On a `start` command it pulls exactly `len` words from the FIFO and presents them on a valid/ready output stream, with `m_last` marking the final word and `done` pulsing on completion. It hides the FIFO's read latency behind a 2-entry skid buffer, so it sustains one word per cycle under continuous `m_ready` and never loses or duplicates a word under backpressure. It sits between a FIFO's read port and a downstream consumer such as the MAC datapath or the UART TX.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `LEN_WIDTH`, 8, width of the transfer length; maximum transfer is 2^LEN_WIDTH-1 words.

- `clk`  in  1  single clock; the FIFO read clock is the same clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `len`  in  LEN_WIDTH  number of words to transfer; sampled with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at the end of a transfer.
- `fifo_rden`  out  1  FIFO read request.
- `fifo_empty`  in  1  FIFO read-side empty flag.
- `fifo_data`  in  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_rden`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  qualifies the final word of a transfer.

## Operation
- Reset state: IDLE, skid buffer empty, all counters 0. Every output is 0 during reset.
- **States**
  - IDLE: `start` with `len≠0` latches `len` into `issue_rem` and `deliv_rem`, then moves to RUN. `start` with `len=0` moves to DONE.
  - RUN: when the last word is popped (`deliv_rem`=1 and pop), moves to DONE.
  - DONE: `done`=1 for one cycle, then returns to IDLE.
- `start` is ignored while `busy`=1.
- Terms used below:
  - `pop` = `m_valid & m_ready`.
  - `cnt` = skid buffer occupancy, 0..2.
  - `inflight` = `fifo_rden` registered one cycle.
- Read issue: `fifo_rden` = RUN & !`fifo_empty` & `issue_rem`≠0 & (`cnt` + `inflight` − `pop`) < 2. `fifo_rden` is never asserted while `fifo_empty`=1.
  - `issue_rem` decrements on each `fifo_rden`.
  - `deliv_rem` decrements on each `pop`.
- `fifo_data` is written into the skid buffer in the cycle after `fifo_rden`, in FIFO order.
- `m_valid` = (`cnt`≠0).
  - `m_data` is the oldest entry; it holds its last value when `cnt`=0 (0 after reset).
  - `m_last` = `m_valid` & (`deliv_rem`=1).
- Stream rule: once `m_valid`=1, `m_valid` and `m_data` stay stable until `pop`.
- Simultaneous write and pop on the skid buffer: both occur and `cnt` is unchanged.
- Reset mid-transfer aborts immediately. Any FIFO word already read but not yet delivered is discarded; that data loss is accepted.

## Timing
- Cycle numbering: `start` is high in cycle 0; state is RUN from cycle 1.
- First `fifo_rden` can occur in cycle 1. First `m_valid` occurs in cycle 3, i.e. 2 cycles after the first read.
- With the FIFO never empty and `m_ready`=1 throughout:
  - `fifo_rden` is high in cycles 1..N.
  - `m_valid` is high in cycles 3..N+2.
  - `done` pulses in cycle N+3.
  - `busy` is high in cycles 1..N+3.
  - The next `start` is accepted in cycle N+4.
- `len`=0: `done` pulses in cycle 1; no `fifo_rden` is issued.
- Under backpressure at most 2 words are buffered; reads resume the same cycle a `pop` frees a slot.

## Structure
- Package `fifo_stream_reader_pkg`: typedef `state_t` enum {IDLE, RUN, DONE} and the constant `SKID_DEPTH`=2.
- Sub-module `stream_skid2`: the 2-entry buffer, with write port, valid/ready read port and `cnt` output.
- The top level holds the FSM, the two counters and the `inflight` register.

## Test plan
- FIFO preloaded 0x11..0x14, `len`=4, `m_ready`=1 → `fifo_rden` high in cycles 1–4; `m_data` = 0x11, 0x12, 0x13, 0x14 in cycles 3–6; `m_last` only in cycle 6; `done` in cycle 7.
- Same preload, `m_ready`=0 in cycles 3–8 → only 2 reads issued; `m_data` holds 0x11; then all 4 words delivered in order, none lost or duplicated.
- `fifo_empty` toggled every other cycle, `len`=6 → `fifo_rden` never high while empty; data order preserved; `done` 1 cycle after the final `pop`.
- `len`=0 → `done` in cycle 1, no `fifo_rden`; a second `start` pulsed while `busy`=1 has no effect.
- `rst` asserted in cycle 4 of a `len`=8 transfer → all outputs 0 in that cycle; after release, a `len`=2 transfer completes correctly.
- `len`=255 with continuous data and `m_ready`=1 → 255 words at one word per cycle; `done` in cycle 258.
